alu_arbiter: RTL and testbench

- Shares the single combinational ALU between two requesters, for example the execute stage and an address/branch unit.
- Each requester offers an {opcode, left, right} operation over a valid/ready handshake.
- The block arbitrates round-robin, drives the ALU operand ports from registers, captures the result, and returns it with the winner's ID over a valid/ready response channel.
- The ALU stays a separate instance, wired to this block's alu_* ports.

---
 rtl/alu_arbiter.sv | 147 ++++++++++++++
 tb/tb_alu_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter that shares one external combinational ALU
// between two requesters. It registers the chosen operands onto the alu_*
// ports, captures the ALU result one cycle later, and returns that result
// with the owner's ID over a valid/ready response channel. Only one operation
// is outstanding at a time.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [2:0]       req0_opcode,
  input  logic [WIDTH-1:0] req0_left,
  input  logic [WIDTH-1:0] req0_right,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [2:0]       req1_opcode,
  input  logic [WIDTH-1:0] req1_left,
  input  logic [WIDTH-1:0] req1_right,
  output logic             req1_ready,
  output logic [2:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_left,
  output logic [WIDTH-1:0] alu_right,
  input  logic [WIDTH-1:0] alu_result,
  output logic             resp_valid,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_result,
  input  logic             resp_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             id_q, id_d;
  logic [2:0]       alu_opcode_q, alu_opcode_d;
  logic [WIDTH-1:0] alu_left_q, alu_left_d;
  logic [WIDTH-1:0] alu_right_q, alu_right_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_id_q, resp_id_d;
  logic [WIDTH-1:0] resp_result_q, resp_result_d;

  logic grant_valid;
  logic grant;

  // Round-robin grant, only while idle: a lone requester wins, otherwise the
  // one that was not served last.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    grant_valid = 1'b0;
    grant       = 1'b0;
    if (state_q == IDLE) begin
      if (req0_valid && req1_valid) begin
        grant_valid = 1'b1;
        grant       = ~last_grant_q;
      end else if (req0_valid) begin
        grant_valid = 1'b1;
        grant       = 1'b0;
      end else if (req1_valid) begin
        grant_valid = 1'b1;
        grant       = 1'b1;
      end
    end
  end

  // A grant only exists when its requester is valid, so a raised ready is an accept.
  assign req0_ready = grant_valid && !grant;
  assign req1_ready = grant_valid &&  grant;

  // Next-state and datapath load decisions for the IDLE -> EXEC -> RESP cycle.
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    id_d          = id_q;
    alu_opcode_d  = alu_opcode_q;
    alu_left_d    = alu_left_q;
    alu_right_d   = alu_right_q;
    resp_valid_d  = resp_valid_q;
    resp_id_d     = resp_id_q;
    resp_result_d = resp_result_q;
    unique case (state_q)
      IDLE: begin
        if (grant_valid) begin
          alu_opcode_d = grant ? req1_opcode : req0_opcode;
          alu_left_d   = grant ? req1_left   : req0_left;
          alu_right_d  = grant ? req1_right  : req0_right;
          id_d         = grant;
          last_grant_d = grant;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        resp_result_d = alu_result;
        resp_id_d     = id_q;
        resp_valid_d  = 1'b1;
        state_d       = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset; reset drops any in-flight operation.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      id_q          <= 1'b0;
      alu_opcode_q  <= '0;
      alu_left_q    <= '0;
      alu_right_q   <= '0;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= 1'b0;
      resp_result_q <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      id_q          <= id_d;
      alu_opcode_q  <= alu_opcode_d;
      alu_left_q    <= alu_left_d;
      alu_right_q   <= alu_right_d;
      resp_valid_q  <= resp_valid_d;
      resp_id_q     <= resp_id_d;
      resp_result_q <= resp_result_d;
    end
  end

  assign alu_opcode  = alu_opcode_q;
  assign alu_left    = alu_left_q;
  assign alu_right   = alu_right_q;
  assign resp_valid  = resp_valid_q;
  assign resp_id     = resp_id_q;
  assign resp_result = resp_result_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed bench for alu_arbiter with a small stand-in ALU.
module tb_alu_arbiter;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req0_valid = 1'b0;
  logic [2:0]       req0_opcode = '0;
  logic [WIDTH-1:0] req0_left = '0;
  logic [WIDTH-1:0] req0_right = '0;
  logic             req0_ready;
  logic             req1_valid = 1'b0;
  logic [2:0]       req1_opcode = '0;
  logic [WIDTH-1:0] req1_left = '0;
  logic [WIDTH-1:0] req1_right = '0;
  logic             req1_ready;
  logic [2:0]       alu_opcode;
  logic [WIDTH-1:0] alu_left;
  logic [WIDTH-1:0] alu_right;
  logic [WIDTH-1:0] alu_result;
  logic             resp_valid;
  logic             resp_id;
  logic [WIDTH-1:0] resp_result;
  logic             resp_ready = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  alu_arbiter #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_opcode (req0_opcode),
    .req0_left   (req0_left),
    .req0_right  (req0_right),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_opcode (req1_opcode),
    .req1_left   (req1_left),
    .req1_right  (req1_right),
    .req1_ready  (req1_ready),
    .alu_opcode  (alu_opcode),
    .alu_left    (alu_left),
    .alu_right   (alu_right),
    .alu_result  (alu_result),
    .resp_valid  (resp_valid),
    .resp_id     (resp_id),
    .resp_result (resp_result),
    .resp_ready  (resp_ready)
  );

  always #5 clk = ~clk;

  // Stand-in ALU: ADD, SUB, AND; any other opcode passes the left operand.
  always_comb begin
    case (alu_opcode)
      3'b000:  alu_result = alu_left + alu_right;
      3'b100:  alu_result = alu_left - alu_right;
      3'b111:  alu_result = alu_left & alu_right;
      default: alu_result = alu_left;
    endcase
  end

  typedef struct {
    logic             id;
    logic [2:0]       op;
    logic [WIDTH-1:0] left;
    logic [WIDTH-1:0] right;
    logic [WIDTH-1:0] exp;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic set_req(input logic id, input logic [2:0] op,
                         input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r);
    if (id == 1'b0) begin
      req0_valid = 1'b1; req0_opcode = op; req0_left = l; req0_right = r;
    end else begin
      req1_valid = 1'b1; req1_opcode = op; req1_left = l; req1_right = r;
    end
  endtask

  // One lone-requester operation from IDLE through the response handshake.
  task automatic run_op(input string tag, input vec_t v);
    set_req(v.id, v.op, v.left, v.right);
    #1;
    check({tag, " own ready"},   v.id ? req1_ready : req0_ready, 1);
    check({tag, " other ready"}, v.id ? req0_ready : req1_ready, 0);
    step();  // accept edge
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check({tag, " alu_opcode"}, alu_opcode, v.op);
    check({tag, " alu_left"},   alu_left,   v.left);
    check({tag, " alu_right"},  alu_right,  v.right);
    check({tag, " no early resp"}, resp_valid, 0);
    step();  // EXEC closes
    check({tag, " resp_valid"},  resp_valid,  1);
    check({tag, " resp_id"},     resp_id,     v.id);
    check({tag, " resp_result"}, resp_result, v.exp);
    resp_ready = 1'b1;
    #1;
    check({tag, " readys low in RESP"}, {req0_ready, req1_ready}, 0);
    step();
    resp_ready = 1'b0;
    check({tag, " resp_valid cleared"}, resp_valid, 0);
  endtask

  initial begin
    vecs[0] = '{id: 1'b0, op: 3'b000, left: 32'd4,       right: 32'd3,       exp: 32'd7};
    vecs[1] = '{id: 1'b0, op: 3'b100, left: 32'd0,       right: 32'd1,       exp: 32'hFFFF_FFFF};
    vecs[2] = '{id: 1'b1, op: 3'b111, left: 32'h0000_F0F0, right: 32'h0000_FF00, exp: 32'h0000_F000};
    vecs[3] = '{id: 1'b0, op: 3'b100, left: 32'd10,      right: 32'd3,       exp: 32'd7};
    vecs[4] = '{id: 1'b1, op: 3'b000, left: 32'd5,       right: 32'd6,       exp: 32'd11};

    // Reset values
    do_reset();
    check("reset resp_valid",  resp_valid,  0);
    check("reset resp_id",     resp_id,     0);
    check("reset resp_result", resp_result, 0);
    check("reset alu_opcode",  alu_opcode,  0);
    check("reset alu_left",    alu_left,    0);
    check("reset alu_right",   alu_right,   0);
    check("reset readys",      {req0_ready, req1_ready}, 0);

    // Table-driven single operations
    for (int i = 0; i < 5; i++) run_op($sformatf("vec%0d", i), vecs[i]);

    // Lone requester 1 right after reset, wrap-around ADD
    do_reset();
    run_op("lone req1", '{id: 1'b1, op: 3'b000, left: 32'hFFFF_FFFF, right: 32'd1, exp: 32'd0});

    // Contention: both valid continuously, alternating winners
    do_reset();
    set_req(1'b0, 3'b111, 32'hC, 32'hA);
    set_req(1'b1, 3'b100, 32'd7, 32'd3);
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("rr%0d req0_ready", i), req0_ready, (i % 2 == 0) ? 1 : 0);
      check($sformatf("rr%0d req1_ready", i), req1_ready, (i % 2 == 1) ? 1 : 0);
      step();
      check($sformatf("rr%0d exec readys", i), {req0_ready, req1_ready}, 0);
      step();
      check($sformatf("rr%0d resp_id", i),     resp_id,     (i % 2 == 0) ? 0 : 1);
      check($sformatf("rr%0d resp_result", i), resp_result, (i % 2 == 0) ? 32'd8 : 32'd4);
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Back-pressure with req1 waiting
    do_reset();
    set_req(1'b0, 3'b000, 32'd4, 32'd3);
    set_req(1'b1, 3'b100, 32'd9, 32'd2);
    #1;
    check("bp req0 wins", {req0_ready, req1_ready}, 2'b10);
    step();
    req0_valid = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp%0d resp_valid", i),  resp_valid,  1);
      check($sformatf("bp%0d resp_id", i),     resp_id,     0);
      check($sformatf("bp%0d resp_result", i), resp_result, 32'd7);
      check($sformatf("bp%0d readys", i),      {req0_ready, req1_ready}, 0);
      check($sformatf("bp%0d alu_left", i),    alu_left,    32'd4);
      check($sformatf("bp%0d alu_right", i),   alu_right,   32'd3);
      step();
    end
    resp_ready = 1'b1;
    #1;
    check("bp no accept at handshake", req1_ready, 0);
    step();
    resp_ready = 1'b0;
    check("bp resp cleared", resp_valid, 0);
    check("bp req1 ready after handshake", req1_ready, 1);
    check("bp alu_left before req1 accept", alu_left, 32'd4);
    step();
    req1_valid = 1'b0;
    check("bp req1 alu_left", alu_left, 32'd9);
    step();
    check("bp req1 resp_id",     resp_id,     1);
    check("bp req1 resp_result", resp_result, 32'd7);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;

    // Reset during EXEC drops the operation
    set_req(1'b0, 3'b000, 32'd2, 32'd2);
    step();
    req0_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst resp_valid",  resp_valid,  0);
    check("midrst resp_result", resp_result, 0);
    check("midrst resp_id",     resp_id,     0);
    check("midrst alu_opcode",  alu_opcode,  0);
    check("midrst alu_left",    alu_left,    0);
    check("midrst alu_right",   alu_right,   0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("midrst quiet%0d", i), resp_valid, 0);
    end
    // last_grant back to 1: req0 wins a tie
    set_req(1'b0, 3'b000, 32'd1, 32'd1);
    set_req(1'b1, 3'b000, 32'd8, 32'd8);
    #1;
    check("midrst tie winner", {req0_ready, req1_ready}, 2'b10);
    req1_valid = 1'b0;
    run_op("midrst next", '{id: 1'b0, op: 3'b000, left: 32'd1, right: 32'd1, exp: 32'd2});

    // Valid pulsed only during RESP: no accept, no extra response
    set_req(1'b1, 3'b000, 32'd5, 32'd5);
    step();
    req1_valid = 1'b0;
    step();
    set_req(1'b0, 3'b100, 32'd50, 32'd1);
    #1;
    check("wd ready during RESP", req0_ready, 0);
    step();
    step();
    req0_valid = 1'b0;
    check("wd resp_result", resp_result, 32'd10);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("wd%0d no resp", i),   resp_valid, 0);
      check($sformatf("wd%0d alu_left", i),  alu_left,   32'd5);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
